// File: rtl/bandai_mapper_gen_if.sv
// Cartridge-side bus between the console and the mapper: strobes, address/data,
// chip selects, banked upper address and the unlock serial pin.
interface bandai_mapper_gen_if #(
  parameter int RADDR_W = 7
);
  logic               cen_n;
  logic               ss_n;
  logic               oe_n;
  logic               we_n;
  logic [7:0]         addr;
  logic [7:0]         dq_i;
  logic [7:0]         dq_o;
  logic               dq_oe;
  logic               so;
  logic               so_oe;
  logic               romce_n;
  logic               ramce_n;
  logic [RADDR_W-1:0] raddr;
  logic               locked;

  modport slave (
    input  cen_n, ss_n, oe_n, we_n, addr, dq_i,
    output dq_o, dq_oe, so, so_oe, romce_n, ramce_n, raddr, locked
  );

  modport master (
    output cen_n, ss_n, oe_n, we_n, addr, dq_i,
    input  dq_o, dq_oe, so, so_oe, romce_n, ramce_n, raddr, locked
  );
endinterface

// File: rtl/bandai_mapper_gen.sv
// Cartridge mapper: bank registers, ROM/SRAM chip-select decode, banked upper
// address generation and the serial unlock stream, all synchronous to i_clk.
module bandai_mapper_gen #(
  parameter int                 RADDR_W     = 7,
  parameter logic [7:0]         UNLOCK_ADDR = 8'hA5,
  parameter int                 SEQ_LEN     = 18,
  parameter logic [SEQ_LEN-1:0] SEQ         = {1'b0, 16'h28A0, 1'b0},
  parameter bit                 RELOCK_EN   = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  bandai_mapper_gen_if.slave   io_bus
);

  localparam int CNT_W = $clog2(SEQ_LEN + 1);

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'd0,
    ST_SHIFT    = 2'd1,
    ST_UNLOCKED = 2'd2
  } state_t;

  // Register file and write-capture state
  logic [7:0] r_lao;
  logic [7:0] r_ramb;
  logic [7:0] r_romb0;
  logic [7:0] r_romb1;
  logic       r_ctrl_wp;
  logic [2:0] r_wa;
  logic [7:0] r_wd;
  logic       r_pend;
  logic       r_strb_prev;

  // Unlock FSM and pin enable
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_so;
  logic             w_so_nxt;
  logic             r_rst_q;
  logic             r_so_oe;

  logic [3:0] w_nib;
  logic       w_sel;
  logic       w_strb;
  logic       w_commit;
  logic       w_trigger;
  logic       w_relock;
  logic       w_locked;
  logic       w_rce;
  logic       w_romce_n;
  logic       w_ramce_n;

  assign w_nib     = io_bus.addr[7:4];
  assign w_sel     = ~(io_bus.ss_n & io_bus.cen_n) &
                     (io_bus.addr >= 8'hC0) & (io_bus.addr <= 8'hC4);
  assign w_strb    = io_bus.oe_n & io_bus.we_n;
  assign w_commit  = w_strb & ~r_strb_prev & r_pend;
  assign w_trigger = (io_bus.addr == UNLOCK_ADDR);
  assign w_relock  = RELOCK_EN & w_commit & (r_wa == 3'd4) & r_wd[7];
  assign w_locked  = (r_state != ST_UNLOCKED);

  // A write is captured on every cycle the strobe is low; the last capture is
  // committed on the first cycle the bus strobes go idle again.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lao       <= 8'hFF;
      r_ramb      <= 8'hFF;
      r_romb0     <= 8'hFF;
      r_romb1     <= 8'hFF;
      r_ctrl_wp   <= 1'b0;
      r_wa        <= 3'd0;
      r_wd        <= 8'h00;
      r_pend      <= 1'b0;
      r_strb_prev <= 1'b1;
    end else begin
      r_strb_prev <= w_strb;
      if (w_sel && !io_bus.we_n) begin
        r_wa   <= io_bus.addr[2:0];
        r_wd   <= io_bus.dq_i;
        r_pend <= 1'b1;
      end else if (w_commit) begin
        r_pend <= 1'b0;
        case (r_wa)
          3'd0:    r_lao     <= r_wd;
          3'd1:    r_ramb    <= r_wd;
          3'd2:    r_romb0   <= r_wd;
          3'd3:    r_romb1   <= r_wd;
          3'd4:    r_ctrl_wp <= r_wd[0];
          default: ;
        endcase
      end
    end
  end

  // SO_OE stays low for the reset cycle and the one after it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rst_q <= 1'b1;
      r_so_oe <= 1'b0;
    end else begin
      r_rst_q <= 1'b0;
      r_so_oe <= ~r_rst_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_LOCKED;
      r_cnt   <= '0;
      r_so    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_so    <= w_so_nxt;
    end
  end

  // r_cnt holds the index of the next stream bit to present on SO.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_so_nxt    = r_so;
    case (r_state)
      ST_LOCKED: begin
        w_so_nxt = 1'b1;
        if (w_trigger) begin
          w_state_nxt = ST_SHIFT;
          w_cnt_nxt   = CNT_W'(1);
          w_so_nxt    = SEQ[0];
        end
      end
      ST_SHIFT: begin
        if (r_cnt == CNT_W'(SEQ_LEN)) begin
          w_state_nxt = ST_UNLOCKED;
          w_cnt_nxt   = '0;
          w_so_nxt    = 1'b1;
        end else begin
          w_so_nxt  = SEQ[r_cnt];
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_UNLOCKED: begin
        w_so_nxt = 1'b1;
        if (w_relock) w_state_nxt = ST_LOCKED;
      end
      default: begin
        w_state_nxt = ST_LOCKED;
        w_cnt_nxt   = '0;
        w_so_nxt    = 1'b1;
      end
    endcase
  end

  // Chip-select decode; an SRAM write while write-protected never selects the chip.
  assign w_rce     = io_bus.ss_n & ~io_bus.cen_n;
  assign w_ramce_n = ~(w_rce & (w_nib == 4'd1) & ~(r_ctrl_wp & ~io_bus.we_n));
  assign w_romce_n = ~(w_rce & (w_nib >= 4'd2));

  always_comb begin
    io_bus.raddr = '0;
    if (!w_romce_n || !w_ramce_n) begin
      if (w_nib >= 4'd4) begin
        io_bus.raddr = {r_lao[RADDR_W-5:0], w_nib};
      end else begin
        case (w_nib)
          4'd1:    io_bus.raddr = r_ramb[RADDR_W-1:0];
          4'd2:    io_bus.raddr = r_romb0[RADDR_W-1:0];
          4'd3:    io_bus.raddr = r_romb1[RADDR_W-1:0];
          default: io_bus.raddr = '0;
        endcase
      end
    end
  end

  always_comb begin
    io_bus.dq_o = 8'h00;
    case (io_bus.addr[2:0])
      3'd0:    io_bus.dq_o = r_lao;
      3'd1:    io_bus.dq_o = r_ramb;
      3'd2:    io_bus.dq_o = r_romb0;
      3'd3:    io_bus.dq_o = r_romb1;
      3'd4:    io_bus.dq_o = {w_locked, 6'b0, r_ctrl_wp};
      default: io_bus.dq_o = 8'h00;
    endcase
  end

  assign io_bus.dq_oe   = w_sel & ~io_bus.oe_n & io_bus.we_n;
  assign io_bus.so      = r_so;
  assign io_bus.so_oe   = r_so_oe;
  assign io_bus.romce_n = w_romce_n;
  assign io_bus.ramce_n = w_ramce_n;
  assign io_bus.locked  = w_locked;

endmodule

// File: tb/tb_bandai_mapper_gen.sv
// Directed bench for bandai_mapper_gen: reset state, unlock stream, register
// writes/readback, decode table, write-protect, relock and mid-stream reset.
module tb_bandai_mapper_gen;

  localparam int RADDR_W = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  // SEQ = {0, 16'h28A0, 0} sent LSB first: ones land at bit 6, 8, 12 and 14.
  int exp_so [18] = '{0,0,0,0,0,0,1,0,1,0,0,0,1,0,1,0,0,0};

  bandai_mapper_gen_if #(.RADDR_W(RADDR_W)) bus ();

  bandai_mapper_gen #(.RADDR_W(RADDR_W)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic               ss_n;
    logic               cen_n;
    logic               oe_n;
    logic               we_n;
    logic [7:0]         addr;
    logic               romce_n;
    logic               ramce_n;
    logic [RADDR_W-1:0] raddr;
    logic               dq_oe;
    logic [7:0]         dq_o;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus.ss_n  = 1'b1;
    bus.cen_n = 1'b1;
    bus.oe_n  = 1'b1;
    bus.we_n  = 1'b1;
    bus.addr  = 8'h00;
    bus.dq_i  = 8'h00;
  endtask

  task automatic reg_write(input logic [7:0] a, input logic [7:0] d);
    bus.ss_n  = 1'b0;
    bus.cen_n = 1'b1;
    bus.addr  = a;
    bus.dq_i  = d;
    bus.we_n  = 1'b0;
    tick();
    bus.we_n  = 1'b1;
    tick();
    bus_idle();
  endtask

  task automatic reg_read(input string name, input logic [7:0] a, input logic [7:0] exp);
    bus.ss_n  = 1'b0;
    bus.cen_n = 1'b1;
    bus.addr  = a;
    bus.we_n  = 1'b1;
    bus.oe_n  = 1'b0;
    #1;
    check({name, "_oe"}, 32'(bus.dq_oe), 32'd1);
    check(name, 32'(bus.dq_o), 32'(exp));
    bus_idle();
    #1;
  endtask

  task automatic trigger_unlock();
    bus.addr = 8'hA5;
    tick();
    bus.addr = 8'h00;
  endtask

  task automatic full_stream(input string tag);
    trigger_unlock();
    for (int i = 0; i < 18; i++) begin
      check($sformatf("%s_so%0d", tag, i), 32'(bus.so), 32'(exp_so[i]));
      check($sformatf("%s_lk%0d", tag, i), 32'(bus.locked), 32'd1);
      tick();
    end
    check({tag, "_so_end"}, 32'(bus.so), 32'd1);
    check({tag, "_unlocked"}, 32'(bus.locked), 32'd0);
  endtask

  initial begin
    bus_idle();

    // Reset held for two edges
    rst = 1'b1;
    tick();
    check("so_oe_in_rst", 32'(bus.so_oe), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("so_oe_after_rst", 32'(bus.so_oe), 32'd0);
    check("so_rst", 32'(bus.so), 32'd1);
    check("locked_rst", 32'(bus.locked), 32'd1);
    tick();
    check("so_oe_on", 32'(bus.so_oe), 32'd1);
    reg_read("rd_lao_rst", 8'hC0, 8'hFF);
    reg_read("rd_ramb_rst", 8'hC1, 8'hFF);
    reg_read("rd_romb0_rst", 8'hC2, 8'hFF);
    reg_read("rd_romb1_rst", 8'hC3, 8'hFF);
    reg_read("rd_ctrl_rst", 8'hC4, 8'h80);

    // Unlock stream
    full_stream("unlock1");
    reg_read("rd_ctrl_unl", 8'hC4, 8'h00);

    // Bank configuration
    reg_write(8'hC2, 8'h2A);
    reg_read("rd_romb0", 8'hC2, 8'h2A);
    reg_write(8'hC0, 8'h05);
    reg_write(8'hC1, 8'h13);
    reg_write(8'hC3, 8'h7C);
    reg_read("rd_lao", 8'hC0, 8'h05);

    //            ss cen oe we addr   rom ram raddr  dqoe dq
    vecs[0]  = '{1, 0, 0, 1, 8'h25, 0, 1, 7'h2A, 0, 8'h00};
    vecs[1]  = '{1, 0, 0, 1, 8'hB3, 0, 1, 7'h5B, 0, 8'h00};
    vecs[2]  = '{1, 0, 0, 1, 8'h10, 1, 0, 7'h13, 0, 8'h00};
    vecs[3]  = '{1, 0, 1, 0, 8'h10, 1, 0, 7'h13, 0, 8'h00};
    vecs[4]  = '{1, 0, 0, 1, 8'h37, 0, 1, 7'h7C, 0, 8'h00};
    vecs[5]  = '{1, 0, 0, 1, 8'h40, 0, 1, 7'h54, 0, 8'h00};
    vecs[6]  = '{1, 0, 0, 1, 8'hF0, 0, 1, 7'h5F, 0, 8'h00};
    vecs[7]  = '{1, 0, 0, 1, 8'h05, 1, 1, 7'h00, 0, 8'h00};
    vecs[8]  = '{1, 1, 0, 1, 8'h25, 1, 1, 7'h00, 0, 8'h00};
    vecs[9]  = '{0, 0, 0, 1, 8'h25, 1, 1, 7'h00, 0, 8'h00};
    vecs[10] = '{0, 1, 0, 1, 8'hC2, 1, 1, 7'h00, 1, 8'h2A};
    vecs[11] = '{1, 0, 0, 1, 8'hC5, 0, 1, 7'h5C, 0, 8'h00};
    vecs[12] = '{1, 0, 0, 1, 8'hC1, 0, 1, 7'h5C, 1, 8'h13};
    vecs[13] = '{0, 1, 0, 1, 8'hC4, 1, 1, 7'h00, 1, 8'h00};
    vecs[14] = '{0, 0, 0, 1, 8'hC3, 1, 1, 7'h00, 1, 8'h7C};

    for (int i = 0; i < 15; i++) begin
      bus.ss_n  = vecs[i].ss_n;
      bus.cen_n = vecs[i].cen_n;
      bus.oe_n  = vecs[i].oe_n;
      bus.we_n  = vecs[i].we_n;
      bus.addr  = vecs[i].addr;
      #1;
      check($sformatf("vec%0d_romce", i), 32'(bus.romce_n), 32'(vecs[i].romce_n));
      check($sformatf("vec%0d_ramce", i), 32'(bus.ramce_n), 32'(vecs[i].ramce_n));
      check($sformatf("vec%0d_raddr", i), 32'(bus.raddr), 32'(vecs[i].raddr));
      check($sformatf("vec%0d_dqoe", i), 32'(bus.dq_oe), 32'(vecs[i].dq_oe));
      if (vecs[i].dq_oe)
        check($sformatf("vec%0d_dq", i), 32'(bus.dq_o), 32'(vecs[i].dq_o));
    end
    bus_idle();
    tick();

    // SRAM write-protect
    reg_write(8'hC4, 8'h01);
    reg_read("rd_ctrl_wp", 8'hC4, 8'h01);
    bus.ss_n = 1'b1; bus.cen_n = 1'b0; bus.addr = 8'h10; bus.we_n = 1'b0;
    #1;
    check("wp_wr_ramce", 32'(bus.ramce_n), 32'd1);
    check("wp_wr_raddr", 32'(bus.raddr), 32'd0);
    bus.we_n = 1'b1; bus.oe_n = 1'b0;
    #1;
    check("wp_rd_ramce", 32'(bus.ramce_n), 32'd0);
    check("wp_rd_raddr", 32'(bus.raddr), 32'h13);
    bus_idle();
    tick();

    // Repeated capture: last value wins; commit lands one edge after strobe rise
    bus.ss_n = 1'b0; bus.cen_n = 1'b1; bus.addr = 8'hC2; bus.we_n = 1'b0; bus.dq_i = 8'h33;
    tick();
    bus.dq_i = 8'h11;
    tick();
    bus.ss_n = 1'b1; bus.cen_n = 1'b0; bus.addr = 8'h25; bus.we_n = 1'b1;
    #1;
    check("pre_commit_raddr", 32'(bus.raddr), 32'h2A);
    tick();
    check("post_commit_raddr", 32'(bus.raddr), 32'h11);
    bus_idle();
    // Strobe rise with nothing pending leaves registers alone
    bus.ss_n = 1'b0; bus.addr = 8'hC0; bus.oe_n = 1'b0;
    tick();
    bus.oe_n = 1'b1;
    tick();
    bus_idle();
    reg_read("rd_lao_nopend", 8'hC0, 8'h05);
    reg_read("rd_romb0_last", 8'hC2, 8'h11);

    // Relock, then a relock write during SHIFT is ignored
    reg_write(8'hC4, 8'h80);
    check("relock1", 32'(bus.locked), 32'd1);
    reg_read("rd_ctrl_relock", 8'hC4, 8'h80);
    trigger_unlock();
    check("shift_so0", 32'(bus.so), 32'(exp_so[0]));
    reg_write(8'hC4, 8'h80);
    check("shift_so2", 32'(bus.so), 32'(exp_so[2]));
    check("shift_relock_ign", 32'(bus.locked), 32'd1);
    for (int i = 3; i < 18; i++) begin
      tick();
      check($sformatf("shift_so%0d", i), 32'(bus.so), 32'(exp_so[i]));
    end
    tick();
    check("shift_unlocked", 32'(bus.locked), 32'd0);
    check("shift_so_end", 32'(bus.so), 32'd1);

    // Reset at stream bit 9, then full replay
    reg_write(8'hC4, 8'h80);
    check("relock2", 32'(bus.locked), 32'd1);
    trigger_unlock();
    for (int i = 0; i < 9; i++) tick();
    check("mid_so9", 32'(bus.so), 32'(exp_so[9]));
    rst = 1'b1;
    tick();
    check("mid_rst_so", 32'(bus.so), 32'd1);
    check("mid_rst_locked", 32'(bus.locked), 32'd1);
    check("mid_rst_so_oe", 32'(bus.so_oe), 32'd0);
    rst = 1'b0;
    tick();
    check("mid_so_oe_hold", 32'(bus.so_oe), 32'd0);
    check("mid_so_idle", 32'(bus.so), 32'd1);
    tick();
    check("mid_so_oe_on", 32'(bus.so_oe), 32'd1);
    reg_read("rd_romb0_rst2", 8'hC2, 8'hFF);
    full_stream("replay");
    reg_write(8'hC4, 8'h80);
    check("relock3", 32'(bus.locked), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
